// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-side datapath slice of the multicycle CPU. Holds the
//             program counter, instruction register and ALUOut register,
//             applies the controller's PC/IR write controls, and decodes the
//             instruction fields. A memory-ready handshake stalls the fetch.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        PCWrite,
   input  logic        PCWriteCond,
   input  logic        IRWrite,
   input  logic [1:0]  PCSource,
   input  logic        Zero,
   input  logic [31:0] ALUResult,
   input  logic [31:0] MemData,
   input  logic        MemReady,
   output logic [31:0] PC,
   output logic [31:0] ALUOut,
   output logic [5:0]  OpCode,
   output logic [4:0]  Rs,
   output logic [4:0]  Rt,
   output logic [4:0]  Rd,
   output logic [5:0]  Funct,
   output logic [31:0] SignExtImm,
   output logic [31:0] JumpTarget,
   output logic        Stall,
   output logic [15:0] InstrCount
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] alu_out_q;
   logic [15:0] cnt_q, cnt_d;
   logic        w_ir_load;
   logic        w_pc_we;
   logic [31:0] w_jump_target;

   // Handshake and write-enable qualification; a stall blocks the PC write
   // so the controller can simply hold its fetch outputs until memory answers.
   always_comb begin
      Stall     = IRWrite & ~MemReady & ~Reset;
      w_ir_load = IRWrite & MemReady;
      w_pc_we   = (PCWrite | (PCWriteCond & Zero)) & ~Stall;
   end

   // Jump target is formed from the current (pre-update) PC and IR.
   assign w_jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};

   // Next-state selection for PC, IR and instruction counter.
   always_comb begin
      pc_d  = pc_q;
      ir_d  = ir_q;
      cnt_d = cnt_q;
      if (w_pc_we) begin
         unique case (PCSource)
            2'b00:   pc_d = ALUResult;
            2'b01:   pc_d = alu_out_q;
            2'b10:   pc_d = w_jump_target;
            default: pc_d = pc_q;       // reserved encoding: hold
         endcase
      end
      if (w_ir_load) begin
         ir_d  = MemData;
         cnt_d = cnt_q + 16'd1;         // natural wrap at 16'hFFFF
      end
   end

   // State registers with synchronous reset taking priority over all inputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q      <= RESET_PC;
         ir_q      <= 32'h0;
         alu_out_q <= 32'h0;
         cnt_q     <= 16'h0;
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         alu_out_q <= ALUResult;        // captured even while stalled
         cnt_q     <= cnt_d;
      end
   end

   // Field outputs are pure slices of the IR register.
   always_comb begin
      PC         = pc_q;
      ALUOut     = alu_out_q;
      InstrCount = cnt_q;
      OpCode     = ir_q[31:26];
      Rs         = ir_q[25:21];
      Rt         = ir_q[20:16];
      Rd         = ir_q[15:11];
      Funct      = ir_q[5:0];
      SignExtImm = {{16{ir_q[15]}}, ir_q[15:0]};
      JumpTarget = w_jump_target;
   end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-side datapath slice of the multicycle CPU, and the consumer of the controller's PC/IR control outputs. It holds the program counter, the instruction register and the ALUOut register. It applies PCWrite, PCWriteCond, IRWrite and PCSource each cycle, and returns the decoded instruction fields, including OpCode, to the controller and the register file. A memory-ready handshake stalls the fetch when instruction memory has not yet returned data.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- PCWrite  in  1  unconditional PC write enable (from controller)
- PCWriteCond  in  1  conditional PC write enable; effective only when Zero=1
- IRWrite  in  1  instruction register load request
- PCSource  in  2  PC next-value select
- Zero  in  1  ALU zero flag
- ALUResult  in  32  combinational ALU output
- MemData  in  32  instruction word from memory
- MemReady  in  1  MemData valid this cycle
- PC  out  32  current program counter (registered)
- ALUOut  out  32  ALUResult registered every cycle
- OpCode  out  6  IR[31:26]
- Rs, Rt, Rd  out  5 each  IR[25:21], IR[20:16], IR[15:11]
- Funct  out  6  IR[5:0]
- SignExtImm  out  32  {{16{IR[15]}}, IR[15:0]}
- JumpTarget  out  32  {PC[31:28], IR[25:0], 2'b00}
- Stall  out  1  fetch stalled waiting on memory
- InstrCount  out  16  count of instructions loaded into IR

## Operation
- Stall = IRWrite & ~MemReady & ~Reset; combinational.
- IR load: when IRWrite & MemReady, IR <= MemData. Otherwise IR holds.
- PC write enable: pc_we = (PCWrite | (PCWriteCond & Zero)) & ~Stall.
- PCSource decode:
  - 2'b00: next PC = ALUResult (PC+4 path)
  - 2'b01: next PC = ALUOut (branch target)
  - 2'b10: next PC = JumpTarget (computed from the current PC and IR)
  - 2'b11: reserved; PC holds even when pc_we=1
- ALUOut <= ALUResult every non-reset cycle, including stalled cycles.
- InstrCount increments by 1 on each IR load. It wraps from 16'hFFFF to 16'h0000.
- All field outputs are combinational slices of the IR register, so they change only when the IR changes.
- PCWrite and PCWriteCond asserted together: a single write occurs, with the same effect as PCWrite alone.
- PCWriteCond=1 with Zero=0 and PCWrite=0: PC holds.
- Reset has priority over every other input:
  - PC=RESET_PC
  - IR=32'h0, so OpCode, Rs, Rt, Rd, Funct and SignExtImm are all 0
  - JumpTarget={RESET_PC[31:28], 28'h0}
  - ALUOut=0, InstrCount=0, Stall=0
- Reset asserted mid-stall: the stall is abandoned, and state equals the post-reset values on the next edge.

## Timing
- PC, IR, ALUOut and InstrCount are registered. New values are visible on the cycle after the qualifying edge.
- OpCode latency: MemData sampled on the edge where IRWrite & MemReady is true; OpCode is valid immediately after that edge.
- Stall has zero latency: it asserts in the same cycle IRWrite is high with MemReady low.
- While stalled, PC, IR and InstrCount hold. The controller is expected to keep its outputs constant (stay in fetch).
- Fetch with MemReady already high: no stall; the IR load and the PC+4 write happen on the same edge.
- JumpTarget uses the pre-update PC[31:28], so a jump issued in the same cycle as a PC write sees the old PC.
- No combinational path from MemData to any output except through the IR register.

## Test plan
- Reset: hold Reset high 2 cycles with random inputs -> PC=RESET_PC, IR=0, OpCode=0, ALUOut=0, InstrCount=0, Stall=0.
- Fetch: MemData=32'h8C22_0004, IRWrite=1, MemReady=1, PCWrite=1, PCSource=00, ALUResult=PC+4 -> next cycle OpCode=6'h23, Rs=1, Rt=2, SignExtImm=4, PC=4, InstrCount=1.
- Stall: IRWrite=1, MemReady=0 for 3 cycles, then 1 with MemData=32'h0800_0010 -> Stall high 3 cycles with PC/IR unchanged; IR loads on the 4th edge; OpCode=6'h02; JumpTarget=32'h0000_0040.
- Branch: PCWriteCond=1, PCSource=01, ALUOut=32'h100; first with Zero=0 -> PC unchanged; then with Zero=1 -> PC=32'h100.
- Jump/reserved: PC=32'hA000_0008, IR=32'h0800_0010, PCWrite=1, PCSource=10 -> PC=32'hA000_0040; then PCSource=11 with PCWrite=1 -> PC holds.
- Wrap and mid-stall reset: 65536 IR loads -> InstrCount returns to 0; assert Reset during Stall -> Stall=0 and reset values on the next edge.
